// File: rtl/switch_arb_pkg.sv
// Shared types and helpers for the switch egress arbitration logic.
package switch_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_XFER} arb_state_t;

  function automatic int port_idx_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: selects the first requester strictly after rr_last,
// wrapping around, using a double-width masked priority search.
module rr_priority_picker
  import switch_arb_pkg::*;
#(
  parameter  int P_NUM_PORTS = 4,
  localparam int IW          = port_idx_width(P_NUM_PORTS)
) (
  input  logic [P_NUM_PORTS-1:0] req,
  input  logic [IW-1:0]          rr_last,
  output logic [P_NUM_PORTS-1:0] gnt_onehot,
  output logic [IW-1:0]          gnt_idx
);

  logic [P_NUM_PORTS-1:0]   hi_mask;
  logic [2*P_NUM_PORTS-1:0] dbl_req;
  logic [2*P_NUM_PORTS-1:0] dbl_gnt;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < P_NUM_PORTS; i++) begin
      hi_mask[i] = (i > int'(rr_last));
    end
  end

  // Lower half holds only ports above rr_last, so it wins when any of them request;
  // the upper half supplies the wrapped-around fallback.
  assign dbl_req    = {req, req & hi_mask};
  assign dbl_gnt    = dbl_req & (-dbl_req);
  assign gnt_onehot = dbl_gnt[P_NUM_PORTS-1:0] | dbl_gnt[2*P_NUM_PORTS-1:P_NUM_PORTS];

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < P_NUM_PORTS; i++) begin
      if (gnt_onehot[i]) gnt_idx = IW'(i);
    end
  end

endmodule

// File: rtl/pkt_rr_egress_arbiter.sv
// Packet-granular round-robin arbiter draining FWFT ingress FIFOs into one valid/ready
// egress stream, with a maximum packet length to survive a missing EOP.
module pkt_rr_egress_arbiter
  import switch_arb_pkg::*;
#(
  parameter  int P_NUM_PORTS     = 4,
  parameter  int P_DATA_WIDTH    = 32,
  parameter  int P_MAX_PKT_WORDS = 64,
  localparam int IW              = port_idx_width(P_NUM_PORTS)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [P_NUM_PORTS-1:0]            empty_i,
  input  logic [P_NUM_PORTS-1:0]            last_i,
  input  logic [P_NUM_PORTS*P_DATA_WIDTH-1:0] data_i,
  output logic [P_NUM_PORTS-1:0]            rd_o,
  output logic [P_DATA_WIDTH-1:0]           data_o,
  output logic                              last_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [IW-1:0]                     gnt_idx_o,
  output logic                              busy_o,
  output logic                              err_trunc_o
);

  localparam int             CW        = $clog2(P_MAX_PKT_WORDS + 1);
  localparam logic [CW-1:0]  CNT_FORCE = CW'(P_MAX_PKT_WORDS - 1);

  arb_state_t             state_q, state_d;
  logic [IW-1:0]          gnt_q, gnt_d;
  logic [IW-1:0]          rr_last_q, rr_last_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic [P_NUM_PORTS-1:0] pick_onehot;
  logic [IW-1:0]          pick_idx;
  logic                   force_rel;
  logic                   accept;
  logic [P_DATA_WIDTH-1:0] head_words [P_NUM_PORTS];

  for (genvar k = 0; k < P_NUM_PORTS; k++) begin : g_heads
    assign head_words[k] = data_i[k*P_DATA_WIDTH +: P_DATA_WIDTH];
  end

  rr_priority_picker #(
    .P_NUM_PORTS (P_NUM_PORTS)
  ) u_picker (
    .req        (~empty_i),
    .rr_last    (rr_last_q),
    .gnt_onehot (pick_onehot),
    .gnt_idx    (pick_idx)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= '0;
      rr_last_q <= IW'(P_NUM_PORTS - 1);
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // Egress mux and read strobe are combinational on the held grant; the grant only
  // changes in IDLE, so a packet is never preempted mid-flight.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_last_d = rr_last_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    valid_o   = 1'b0;
    data_o    = '0;
    last_o    = 1'b0;
    rd_o      = '0;
    accept    = 1'b0;
    force_rel = (cnt_q == CNT_FORCE);

    case (state_q)
      ARB_IDLE: begin
        if (|pick_onehot) begin
          gnt_d   = pick_idx;
          state_d = ARB_XFER;
        end
      end
      ARB_XFER: begin
        valid_o     = ~empty_i[gnt_q];
        data_o      = head_words[gnt_q];
        last_o      = last_i[gnt_q] | force_rel;
        accept      = valid_o & ready_i;
        rd_o[gnt_q] = accept;
        if (accept) begin
          if (last_o) begin
            rr_last_d = gnt_q;
            cnt_d     = '0;
            state_d   = ARB_IDLE;
            err_d     = force_rel & ~last_i[gnt_q];
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign gnt_idx_o   = gnt_q;
  assign busy_o      = (state_q == ARB_XFER);
  assign err_trunc_o = err_q;

endmodule

// File: tb/tb_pkt_rr_egress_arbiter.sv
// Directed self-checking bench for pkt_rr_egress_arbiter with four modelled FWFT FIFOs
// and a 4-word maximum packet length.
module tb_pkt_rr_egress_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  empty_i;
  logic [3:0]  last_i;
  logic [127:0] data_i;
  logic [3:0]  rd_o;
  logic [31:0] data_o;
  logic        last_o;
  logic        valid_o;
  logic        ready_i;
  logic [1:0]  gnt_idx_o;
  logic        busy_o;
  logic        err_trunc_o;

  int          num_checks;
  int          num_fails;
  logic [32:0] fifo_q [4][$];
  logic [3:0]  pop_mask;

  pkt_rr_egress_arbiter #(
    .P_NUM_PORTS     (4),
    .P_DATA_WIDTH    (32),
    .P_MAX_PKT_WORDS (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .empty_i     (empty_i),
    .last_i      (last_i),
    .data_i      (data_i),
    .rd_o        (rd_o),
    .data_o      (data_o),
    .last_o      (last_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .gnt_idx_o   (gnt_idx_o),
    .busy_o      (busy_o),
    .err_trunc_o (err_trunc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic drive_heads();
    for (int k = 0; k < 4; k++) begin
      if (fifo_q[k].size() > 0) begin
        empty_i[k]          = 1'b0;
        last_i[k]           = fifo_q[k][0][32];
        data_i[k*32 +: 32]  = fifo_q[k][0][31:0];
      end else begin
        empty_i[k]          = 1'b1;
        last_i[k]           = 1'b0;
        data_i[k*32 +: 32]  = '0;
      end
    end
  endtask

  task automatic push_word(input int port, input logic last, input logic [31:0] data);
    fifo_q[port].push_back({last, data});
    drive_heads();
  endtask

  // FIFO model pops whatever the DUT strobed at the edge, a little after the edge.
  always @(posedge clk) begin
    pop_mask = rd_o;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (pop_mask[k]) begin
        if (fifo_q[k].size() == 0) checkOutput("rd_on_empty", 64'(pop_mask[k]), 64'(0));
        else void'(fifo_q[k].pop_front());
      end
    end
    drive_heads();
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expectOut(input string tag, input logic e_busy, input logic [1:0] e_gnt,
                           input logic e_valid, input logic [31:0] e_data, input logic e_last,
                           input logic [3:0] e_rd, input logic e_err);
    checkOutput({tag, ".busy"},  64'(busy_o),      64'(e_busy));
    checkOutput({tag, ".gnt"},   64'(gnt_idx_o),   64'(e_gnt));
    checkOutput({tag, ".valid"}, 64'(valid_o),     64'(e_valid));
    checkOutput({tag, ".data"},  64'(data_o),      64'(e_data));
    checkOutput({tag, ".last"},  64'(last_o),      64'(e_last));
    checkOutput({tag, ".rd"},    64'(rd_o),        64'(e_rd));
    checkOutput({tag, ".err"},   64'(err_trunc_o), 64'(e_err));
  endtask

  initial begin
    logic [31:0] d;
    num_checks = 0;
    num_fails  = 0;
    rst        = 1'b1;
    ready_i    = 1'b1;
    drive_heads();
    #1;
    expectOut("reset", 0, 0, 0, 32'h0, 0, 4'b0000, 0);

    // Single 3-word packet from port 2.
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] single packet on port 2");
    push_word(2, 0, 32'h2000_0001);
    push_word(2, 0, 32'h2000_0002);
    push_word(2, 1, 32'h2000_0003);
    #1;
    expectOut("t1.idle", 0, 0, 0, 32'h0, 0, 4'b0000, 0);
    tick(); expectOut("t1.w1", 1, 2, 1, 32'h2000_0001, 0, 4'b0100, 0);
    tick(); expectOut("t1.w2", 1, 2, 1, 32'h2000_0002, 0, 4'b0100, 0);
    tick(); expectOut("t1.w3", 1, 2, 1, 32'h2000_0003, 1, 4'b0100, 0);
    tick(); expectOut("t1.end", 0, 2, 0, 32'h0, 0, 4'b0000, 0);

    // Fresh reset, then all ports hold 1-word packets: strict rotation from port 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] round-robin rotation");
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 4; k++) push_word(k, 1, 32'hA000_0000 + 32'(k*16 + n));
    end
    #1;
    expectOut("t2.idle", 0, 0, 0, 32'h0, 0, 4'b0000, 0);
    for (int i = 0; i < 8; i++) begin
      d = 32'hA000_0000 + 32'((i % 4)*16 + i/4);
      tick(); expectOut($sformatf("t2.g%0d", i), 1, 2'(i % 4), 1, d, 1, 4'(1 << (i % 4)), 0);
      tick(); expectOut($sformatf("t2.b%0d", i), 0, 2'(i % 4), 0, 32'h0, 0, 4'b0000, 0);
    end

    // Port 1, 4-word packet with a 3-cycle downstream stall before word 3.
    $display("[TB] backpressure stall");
    push_word(1, 0, 32'h1100_0001);
    push_word(1, 0, 32'h1100_0002);
    push_word(1, 0, 32'h1100_0003);
    push_word(1, 1, 32'h1100_0004);
    #1;
    expectOut("t3.idle", 0, 3, 0, 32'h0, 0, 4'b0000, 0);
    tick(); expectOut("t3.w1", 1, 1, 1, 32'h1100_0001, 0, 4'b0010, 0);
    tick(); expectOut("t3.w2", 1, 1, 1, 32'h1100_0002, 0, 4'b0010, 0);
    tick();
    ready_i = 1'b0;
    #1;
    expectOut("t3.stall0", 1, 1, 1, 32'h1100_0003, 0, 4'b0000, 0);
    for (int i = 1; i <= 3; i++) begin
      tick(); expectOut($sformatf("t3.stall%0d", i), 1, 1, 1, 32'h1100_0003, 0, 4'b0000, 0);
    end
    ready_i = 1'b1;
    #1;
    expectOut("t3.w3", 1, 1, 1, 32'h1100_0003, 0, 4'b0010, 0);
    tick(); expectOut("t3.w4", 1, 1, 1, 32'h1100_0004, 1, 4'b0010, 0);
    tick(); expectOut("t3.end", 0, 1, 0, 32'h0, 0, 4'b0000, 0);

    // Port 1 runs dry mid-packet while port 0 waits; no preemption.
    $display("[TB] source underrun holds grant");
    push_word(1, 0, 32'h1200_0001);
    push_word(1, 0, 32'h1200_0002);
    #1;
    expectOut("t4.idle", 0, 1, 0, 32'h0, 0, 4'b0000, 0);
    tick(); expectOut("t4.w1", 1, 1, 1, 32'h1200_0001, 0, 4'b0010, 0);
    tick(); expectOut("t4.w2", 1, 1, 1, 32'h1200_0002, 0, 4'b0010, 0);
    push_word(0, 1, 32'h0400_0001);
    tick(); expectOut("t4.dry1", 1, 1, 0, 32'h0, 0, 4'b0000, 0);
    tick(); expectOut("t4.dry2", 1, 1, 0, 32'h0, 0, 4'b0000, 0);
    push_word(1, 1, 32'h1200_0003);
    #1;
    expectOut("t4.w3", 1, 1, 1, 32'h1200_0003, 1, 4'b0010, 0);
    tick(); expectOut("t4.gap", 0, 1, 0, 32'h0, 0, 4'b0000, 0);
    tick(); expectOut("t4.p0", 1, 0, 1, 32'h0400_0001, 1, 4'b0001, 0);
    tick(); expectOut("t4.end", 0, 0, 0, 32'h0, 0, 4'b0000, 0);

    // Port 3 overruns the 4-word limit: forced EOP, error pulse, tail re-arbitrated.
    $display("[TB] forced release");
    for (int i = 1; i <= 6; i++) push_word(3, (i == 6), 32'h3300_0000 + 32'(i));
    #1;
    expectOut("t5.idle", 0, 0, 0, 32'h0, 0, 4'b0000, 0);
    tick(); expectOut("t5.w1", 1, 3, 1, 32'h3300_0001, 0, 4'b1000, 0);
    tick(); expectOut("t5.w2", 1, 3, 1, 32'h3300_0002, 0, 4'b1000, 0);
    tick(); expectOut("t5.w3", 1, 3, 1, 32'h3300_0003, 0, 4'b1000, 0);
    tick(); expectOut("t5.w4", 1, 3, 1, 32'h3300_0004, 1, 4'b1000, 0);
    tick(); expectOut("t5.err", 0, 3, 0, 32'h0, 0, 4'b0000, 1);
    tick(); expectOut("t5.w5", 1, 3, 1, 32'h3300_0005, 0, 4'b1000, 0);
    tick(); expectOut("t5.w6", 1, 3, 1, 32'h3300_0006, 1, 4'b1000, 0);
    tick(); expectOut("t5.end", 0, 3, 0, 32'h0, 0, 4'b0000, 0);

    // Reset between edges mid-packet on port 2; afterwards port 0 wins first.
    $display("[TB] reset mid-packet");
    push_word(2, 0, 32'h2200_0001);
    push_word(2, 0, 32'h2200_0002);
    push_word(2, 1, 32'h2200_0003);
    #1;
    expectOut("t6.idle", 0, 3, 0, 32'h0, 0, 4'b0000, 0);
    tick(); expectOut("t6.w1", 1, 2, 1, 32'h2200_0001, 0, 4'b0100, 0);
    push_word(0, 1, 32'h0600_0001);
    push_word(3, 1, 32'h3600_0001);
    tick(); expectOut("t6.w2", 1, 2, 1, 32'h2200_0002, 0, 4'b0100, 0);
    #2;
    rst = 1'b1;
    #1;
    expectOut("t6.rst", 0, 0, 0, 32'h0, 0, 4'b0000, 0);
    @(negedge clk);
    expectOut("t6.rst_hold", 0, 0, 0, 32'h0, 0, 4'b0000, 0);
    rst = 1'b0;
    #1;
    expectOut("t6.rel", 0, 0, 0, 32'h0, 0, 4'b0000, 0);
    tick(); expectOut("t6.p0", 1, 0, 1, 32'h0600_0001, 1, 4'b0001, 0);
    tick(); expectOut("t6.gap0", 0, 0, 0, 32'h0, 0, 4'b0000, 0);
    tick(); expectOut("t6.p2w2", 1, 2, 1, 32'h2200_0002, 0, 4'b0100, 0);
    tick(); expectOut("t6.p2w3", 1, 2, 1, 32'h2200_0003, 1, 4'b0100, 0);
    tick(); expectOut("t6.gap2", 0, 2, 0, 32'h0, 0, 4'b0000, 0);
    tick(); expectOut("t6.p3", 1, 3, 1, 32'h3600_0001, 1, 4'b1000, 0);
    tick(); expectOut("t6.end", 0, 3, 0, 32'h0, 0, 4'b0000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
